// File: rtl/mem_bus_rr_arbiter.sv
// Two-requester round-robin arbiter onto a single valid/ready memory target.
// One transaction per BUSY visit, with a cycle-count timeout that forces an error completion.
module mem_bus_rr_arbiter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid_i,
  output logic                  r0_ready_o,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  input  logic [3:0]            r0_we_i,
  output logic [DATA_WIDTH-1:0] r0_rdata_o,
  input  logic                  r1_valid_i,
  output logic                  r1_ready_o,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  input  logic [3:0]            r1_we_i,
  output logic [DATA_WIDTH-1:0] r1_rdata_o,
  output logic                  t_valid_o,
  input  logic                  t_ready_i,
  output logic [ADDR_WIDTH-1:0] t_addr_o,
  output logic [DATA_WIDTH-1:0] t_wdata_o,
  output logic [3:0]            t_we_o,
  input  logic [DATA_WIDTH-1:0] t_rdata_i,
  output logic                  gnt_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                state_r;
  logic                  gnt_r;
  logic                  last_r;
  logic [15:0]           cnt_r;

  logic                  busy_s;
  logic                  own_valid_s;
  logic [ADDR_WIDTH-1:0] own_addr_s;
  logic [DATA_WIDTH-1:0] own_wdata_s;
  logic [3:0]            own_we_s;
  logic                  done_s;
  logic                  timeout_s;
  logic                  ready_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // Owner mux and completion decode; a target response in the timeout cycle wins over the timeout.
  always_comb begin
    busy_s = (state_r == BUSY);
    if (gnt_r) begin
      own_valid_s = r1_valid_i;
      own_addr_s  = r1_addr_i;
      own_wdata_s = r1_wdata_i;
      own_we_s    = r1_we_i;
    end else begin
      own_valid_s = r0_valid_i;
      own_addr_s  = r0_addr_i;
      own_wdata_s = r0_wdata_i;
      own_we_s    = r0_we_i;
    end
    done_s    = busy_s & t_ready_i;
    timeout_s = busy_s & own_valid_s & ~t_ready_i & (cnt_r == CNT_LAST);
  end

  // Target side: driven from the owner only while BUSY, quiet in IDLE.
  always_comb begin
    if (busy_s) begin
      t_valid_o = own_valid_s & ~timeout_s;
      t_addr_o  = own_addr_s;
      t_wdata_o = own_wdata_s;
      t_we_o    = own_we_s;
    end else begin
      t_valid_o = 1'b0;
      t_addr_o  = '0;
      t_wdata_o = '0;
      t_we_o    = 4'd0;
    end
  end

  // Requester side: completion pulses are suppressed during reset so an abandoned transfer never completes.
  always_comb begin
    ready_s = (done_s | timeout_s) & ~rst;
    if (!busy_s) begin
      rdata_s = '0;
    end else if (timeout_s) begin
      rdata_s = ERR_RDATA;
    end else begin
      rdata_s = t_rdata_i;
    end
    if (gnt_r) begin
      r0_ready_o = 1'b0;
      r0_rdata_o = '0;
      r1_ready_o = ready_s;
      r1_rdata_o = rdata_s;
    end else begin
      r0_ready_o = ready_s;
      r0_rdata_o = rdata_s;
      r1_ready_o = 1'b0;
      r1_rdata_o = '0;
    end
    err_o = timeout_s & ~rst;
  end

  // Arbitration FSM; last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
      cnt_r   <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= 16'd0;
          if (r0_valid_i && r1_valid_i) begin
            gnt_r   <= ~last_r;
            state_r <= BUSY;
          end else if (r0_valid_i) begin
            gnt_r   <= 1'b0;
            state_r <= BUSY;
          end else if (r1_valid_i) begin
            gnt_r   <= 1'b1;
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (done_s || timeout_s) begin
            last_r  <= gnt_r;
            cnt_r   <= 16'd0;
            state_r <= IDLE;
          end else if (!own_valid_s) begin
            cnt_r   <= 16'd0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

  assign gnt_o  = gnt_r;
  assign busy_o = busy_s;

endmodule

// File: tb/tb_mem_bus_rr_arbiter.sv
// Directed bench for mem_bus_rr_arbiter with TIMEOUT_CYCLES=4; inputs change and outputs
// are sampled just after the falling edge.
module tb_mem_bus_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_addr, r0_wdata, r0_rdata, r1_addr, r1_wdata, r1_rdata;
  logic [3:0]  r0_we, r1_we, t_we;
  logic        t_valid, t_ready, gnt, busy, err;
  logic [31:0] t_addr, t_wdata, t_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_bus_rr_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata), .r0_we_i(r0_we), .r0_rdata_o(r0_rdata),
    .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata), .r1_we_i(r1_we), .r1_rdata_o(r1_rdata),
    .t_valid_o(t_valid), .t_ready_i(t_ready), .t_addr_o(t_addr),
    .t_wdata_o(t_wdata), .t_we_o(t_we), .t_rdata_i(t_rdata),
    .gnt_o(gnt), .busy_o(busy), .err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to the next falling edge (one posedge passes in between).
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    r0_valid = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0; r0_we = 4'd0;
    r1_valid = 1'b0; r1_addr = 32'd0; r1_wdata = 32'd0; r1_we = 4'd0;
    t_ready  = 1'b0; t_rdata = 32'd0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    reset_dut();
    settle();
    check("rst_busy", busy, 32'd0);
    check("rst_gnt", gnt, 32'd0);
    check("rst_tvalid", t_valid, 32'd0);
    check("rst_err", err, 32'd0);
    check("rst_rdy", {r0_ready, r1_ready}, 32'd0);
    check("rst_taddr", t_addr, 32'd0);

    // Single read by r0, target ready on 3rd BUSY cycle
    r0_valid = 1'b1; r0_addr = 32'h100;
    settle();
    check("rd_idle_tvalid", t_valid, 32'd0);
    step(); settle();
    check("rd_busy", busy, 32'd1);
    check("rd_gnt", gnt, 32'd0);
    check("rd_tvalid", t_valid, 32'd1);
    check("rd_taddr", t_addr, 32'h100);
    check("rd_rdy_wait", r0_ready, 32'd0);
    step();
    step();
    t_ready = 1'b1; t_rdata = 32'h12345678;
    settle();
    check("rd_r0_ready", r0_ready, 32'd1);
    check("rd_r0_rdata", r0_rdata, 32'h12345678);
    check("rd_r1_ready", r1_ready, 32'd0);
    check("rd_r1_rdata", r1_rdata, 32'd0);
    check("rd_err", err, 32'd0);
    step();
    t_ready = 1'b0; r0_valid = 1'b0;
    settle();
    check("rd_done_idle", busy, 32'd0);
    check("rd_done_rdy", r0_ready, 32'd0);

    // Tie after reset: r0, r1, r0
    reset_dut();
    r0_valid = 1'b1; r0_addr = 32'h10;
    r1_valid = 1'b1; r1_addr = 32'h20;
    step(); settle();
    check("tie1_gnt", gnt, 32'd0);
    check("tie1_taddr", t_addr, 32'h10);
    t_ready = 1'b1; t_rdata = 32'hA;
    settle();
    check("tie1_rdy", {r0_ready, r1_ready}, 32'd2);
    step();
    t_ready = 1'b0;
    settle();
    check("tie_gap_busy", busy, 32'd0);
    check("tie_gap_tvalid", t_valid, 32'd0);
    step(); settle();
    check("tie2_gnt", gnt, 32'd1);
    check("tie2_taddr", t_addr, 32'h20);
    t_ready = 1'b1;
    settle();
    check("tie2_rdy", {r0_ready, r1_ready}, 32'd1);
    step();
    t_ready = 1'b0;
    settle();
    check("tie2_gap_busy", busy, 32'd0);
    step(); settle();
    check("tie3_gnt", gnt, 32'd0);
    check("tie3_busy", busy, 32'd1);
    t_ready = 1'b1;
    step();
    clear_inputs();

    // Write routing from r1
    r1_valid = 1'b1; r1_addr = 32'h2000; r1_wdata = 32'hA5A5A5A5; r1_we = 4'b0011;
    step(); settle();
    check("wr_busy", busy, 32'd1);
    check("wr_gnt", gnt, 32'd1);
    check("wr_tvalid", t_valid, 32'd1);
    check("wr_taddr", t_addr, 32'h2000);
    check("wr_twdata", t_wdata, 32'hA5A5A5A5);
    check("wr_twe", t_we, 32'd3);
    t_ready = 1'b1;
    settle();
    check("wr_r1_ready", r1_ready, 32'd1);
    step();
    clear_inputs();

    // t_ready in IDLE is ignored
    t_ready = 1'b1; t_rdata = 32'h55;
    settle();
    check("idle_trdy_rdy", {r0_ready, r1_ready}, 32'd0);
    check("idle_trdy_rdata", r0_rdata, 32'd0);
    step(); settle();
    check("idle_trdy_busy", busy, 32'd0);
    t_ready = 1'b0;

    // Timeout: target never ready
    r0_valid = 1'b1; r0_addr = 32'h300;
    for (int c = 1; c <= 3; c++) begin
      step(); settle();
      check("to_wait_err", err, 32'd0);
    end
    check("to_wait_tvalid", t_valid, 32'd1);
    step(); settle();
    check("to_r0_ready", r0_ready, 32'd1);
    check("to_r0_rdata", r0_rdata, 32'hDEADBEEF);
    check("to_err", err, 32'd1);
    check("to_tvalid", t_valid, 32'd0);
    check("to_r1_ready", r1_ready, 32'd0);
    step();
    r0_valid = 1'b0;
    settle();
    check("to_idle_busy", busy, 32'd0);
    check("to_idle_err", err, 32'd0);

    // Target ready exactly at the timeout cycle
    r0_valid = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    step();
    t_ready = 1'b1; t_rdata = 32'h1;
    settle();
    check("tor_r0_ready", r0_ready, 32'd1);
    check("tor_r0_rdata", r0_rdata, 32'h1);
    check("tor_err", err, 32'd0);
    check("tor_tvalid", t_valid, 32'd1);
    step();
    clear_inputs();
    settle();
    check("tor_idle_busy", busy, 32'd0);

    // Reset mid-transaction (last is 0 here, so the later tie would pick r1 without the reset)
    r1_valid = 1'b1;
    step(); settle();
    check("rm_gnt1", gnt, 32'd1);
    step();
    rst = 1'b1;
    settle();
    check("rm_rst_rdy", {r0_ready, r1_ready}, 32'd0);
    check("rm_rst_err", err, 32'd0);
    step();
    rst = 1'b0;
    settle();
    check("rm_busy", busy, 32'd0);
    check("rm_gnt", gnt, 32'd0);
    check("rm_post_rdy", {r0_ready, r1_ready, err}, 32'd0);
    r0_valid = 1'b1;
    step(); settle();
    check("rm_tie_gnt", gnt, 32'd0);
    check("rm_tie_busy", busy, 32'd1);
    t_ready = 1'b1;
    step();
    clear_inputs();

    // Abort by r1 leaves last at 0, so the next tie grants r1
    r1_valid = 1'b1;
    step(); settle();
    check("ab_gnt", gnt, 32'd1);
    r1_valid = 1'b0;
    settle();
    check("ab_tvalid", t_valid, 32'd0);
    check("ab_rdy", {r0_ready, r1_ready, err}, 32'd0);
    step(); settle();
    check("ab_idle", busy, 32'd0);
    r0_valid = 1'b1; r1_valid = 1'b1;
    step(); settle();
    check("ab_tie_gnt", gnt, 32'd1);
    t_ready = 1'b1;
    step();
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_rr_arbiter.md
MEM_BUS_RR_ARBITER -- requirements
Module: mem_bus_rr_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  ADDR_WIDTH, 32, address width.
  DATA_WIDTH, 32, data width.
  TIMEOUT_CYCLES, 255, cycles of BUSY without t_ready_i before forced completion; legal range 1..65535.
  ERR_RDATA, 32'hDEADBEEF, rdata returned on timeout.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning; clock and reset first.
  clk  in  1  single clock, all state on rising edge.
  rst  in  1  reset; synchronous, active-high.
  r0_valid_i  in  1  requester 0 request, held until r0_ready_o.
  r0_ready_o  out  1  requester 0 completion pulse.
  r0_addr_i  in  ADDR_WIDTH  requester 0 address.
  r0_wdata_i  in  DATA_WIDTH  requester 0 write data.
  r0_we_i  in  4  requester 0 byte write enables; 0 means read.
  r0_rdata_o  out  DATA_WIDTH  requester 0 read data.
  r1_valid_i, r1_ready_o, r1_addr_i, r1_wdata_i, r1_we_i, r1_rdata_o: same as requester 0, for requester 1.
  t_valid_o  out  1  target request.
  t_ready_i  in  1  target completion pulse.
  t_addr_o  out  ADDR_WIDTH  target address.
  t_wdata_o  out  DATA_WIDTH  target write data.
  t_we_o  out  4  target byte enables.
  t_rdata_i  in  DATA_WIDTH  target read data, valid with t_ready_i.
  gnt_o  out  1  current or last owner index.
  busy_o  out  1  high in BUSY.
  err_o  out  1  one-cycle timeout pulse.

Function
REQ-003 SHALL implement two states, IDLE and BUSY, with registered gnt (owner), last (last served) and a 16-bit timeout counter cnt.
REQ-004 In IDLE with exactly one r*_valid_i high, the arbiter SHALL load gnt with that index and go to BUSY on the next edge.
REQ-005 In IDLE with both valid high, the arbiter SHALL grant the index not equal to last (round-robin).
REQ-006 In IDLE with no valid, the arbiter SHALL hold its state, gnt, and last.
REQ-007 In IDLE, t_valid_o and both r*_ready_o SHALL be 0; arbitration costs exactly one cycle.
REQ-008 In BUSY, t_valid_o, t_addr_o, t_wdata_o and t_we_o SHALL be combinationally driven from requester gnt; t_valid_o SHALL equal that requester's valid.
REQ-009 In IDLE, t_addr_o, t_wdata_o and t_we_o SHALL be 0.
REQ-010 In BUSY, r[gnt]_ready_o SHALL equal t_ready_i and r[gnt]_rdata_o SHALL equal t_rdata_i combinationally (zero added latency).
REQ-011 The non-granted requester SHALL see ready 0 and rdata 0.
REQ-012 On t_ready_i in BUSY, the arbiter SHALL set last to gnt, clear cnt, and go to IDLE on the next edge.
REQ-013 In BUSY without t_ready_i, cnt SHALL increment by 1 per cycle.
REQ-014 When cnt equals TIMEOUT_CYCLES-1 and t_ready_i is low, the arbiter SHALL, in that cycle:
  - pulse r[gnt]_ready_o with r[gnt]_rdata_o = ERR_RDATA;
  - pulse err_o;
  - force t_valid_o to 0.
  On the next edge it SHALL set last to gnt, clear cnt, and go to IDLE.
REQ-015 If t_ready_i and the timeout condition coincide, the target response SHALL win: normal completion with no err_o.
REQ-016 If r[gnt]_valid_i drops in BUSY without t_ready_i (protocol abort), the arbiter SHALL go to IDLE on the next edge with cnt cleared and last unchanged.
REQ-017 The arbiter SHALL complete at most one transaction per BUSY visit; back-to-back requests SHALL be separated by one IDLE cycle.
REQ-018 t_ready_i asserted in IDLE SHALL be ignored.
REQ-019 gnt_o SHALL equal gnt, and busy_o SHALL equal (state == BUSY).

Reset
REQ-020 While rst is high at an edge, the arbiter SHALL load state IDLE, gnt 0, last 1 (requester 0 wins the first tie), cnt 0; all outputs then read 0.
REQ-021 rst asserted mid-BUSY SHALL abandon the transaction without a ready or err pulse to either requester.

Verification
REQ-022 Bench SHALL cover single read: r0 read addr 0x100, target ready 2 cycles after t_valid_o with rdata 0x12345678 -> r0_ready_o for one cycle with r0_rdata_o 0x12345678, r1 sees ready 0.
REQ-023 Bench SHALL cover tie after reset: both valid in the first IDLE -> r0 served first, then r1 after one IDLE cycle, then r0 again if both are still requesting.
REQ-024 Bench SHALL cover write routing: r1 write addr 0x2000, wdata 0xA5A5A5A5, we 4'b0011 -> identical values on t_addr_o, t_wdata_o, t_we_o while busy_o=1 and gnt_o=1.
REQ-025 Bench SHALL cover timeout: TIMEOUT_CYCLES=4, target never ready -> on the 4th BUSY cycle r0_ready_o=1, r0_rdata_o=0xDEADBEEF, err_o=1, t_valid_o=0; IDLE next cycle.
REQ-026 Bench SHALL cover ready at the timeout cycle: TIMEOUT_CYCLES=4, t_ready_i on the 4th BUSY cycle with rdata 0x1 -> r0_rdata_o=0x1, err_o=0.
REQ-027 Bench SHALL cover reset mid-transaction: rst high on the 2nd BUSY cycle -> next cycle busy_o=0, gnt_o=0, no ready or err pulse; a following tie grants r0.
